// File: rtl/t07_memory_handler_if.sv
// Data-bus bundle between the memory handler (master) and the memory/bus fabric (slave).
interface t07_memory_handler_if;
  logic        busRead;
  logic        busWrite;
  logic [31:0] busAddr;
  logic [31:0] busDataOut;
  logic [3:0]  busSel;
  logic        busAck;
  logic [31:0] busDataIn;

  modport master (
    output busRead, busWrite, busAddr, busDataOut, busSel,
    input  busAck, busDataIn
  );

  modport slave (
    input  busRead, busWrite, busAddr, busDataOut, busSel,
    output busAck, busDataIn
  );
endinterface

// File: rtl/t07_memory_handler.sv
// Load/store responder: runs one data-bus transaction per memRead/memWrite, formats
// byte/half/word lanes, and freezes the core until ack, timeout or misalignment.
module t07_memory_handler #(
  parameter int TIMEOUT = 255
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         memRead,
  input  logic                         memWrite,
  input  logic [2:0]                   funct3,
  input  logic [31:0]                  addr,
  input  logic [31:0]                  storeData,
  t07_memory_handler_if.master         bus,
  output logic [31:0]                  loadData,
  output logic                         freeze,
  output logic                         misaligned,
  output logic                         busErr
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state;
  logic [CW-1:0]  count;
  logic [2:0]     f3Q;
  logic [1:0]     offQ;
  logic           isWrite;

  logic           reqMis;
  logic [3:0]     reqSel;
  logic [31:0]    reqData;
  logic [7:0]     byteLane;
  logic [15:0]    halfLane;
  logic [31:0]    fmtLoad;

  // funct3[1:0] picks the size; 011/110/111 fall through to word
  always_comb begin
    reqMis  = 1'b0;
    reqSel  = 4'b1111;
    reqData = storeData;
    if (funct3[1:0] == 2'b00) begin
      reqSel  = 4'b0001 << addr[1:0];
      reqData = {4{storeData[7:0]}};
    end else if (funct3[1:0] == 2'b01) begin
      reqSel  = 4'b0011 << {addr[1], 1'b0};
      reqData = {2{storeData[15:0]}};
      reqMis  = addr[0];
    end else begin
      reqMis  = (addr[1:0] != 2'b00);
    end
  end

  // funct3[2] set means unsigned for the byte/half sizes
  always_comb begin
    byteLane = bus.busDataIn[{offQ, 3'b000} +: 8];
    halfLane = offQ[1] ? bus.busDataIn[31:16] : bus.busDataIn[15:0];
    fmtLoad  = bus.busDataIn;
    if (f3Q[1:0] == 2'b00)
      fmtLoad = {{24{~f3Q[2] & byteLane[7]}}, byteLane};
    else if (f3Q[1:0] == 2'b01)
      fmtLoad = {{16{~f3Q[2] & halfLane[15]}}, halfLane};
  end

  assign freeze = nrst & (((state == IDLE) & (memRead | memWrite)) | (state == BUSY));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state          <= IDLE;
      count          <= '0;
      f3Q            <= 3'b000;
      offQ           <= 2'b00;
      isWrite        <= 1'b0;
      bus.busRead    <= 1'b0;
      bus.busWrite   <= 1'b0;
      bus.busAddr    <= 32'h0;
      bus.busDataOut <= 32'h0;
      bus.busSel     <= 4'b0000;
      loadData       <= 32'h0;
      misaligned     <= 1'b0;
      busErr         <= 1'b0;
    end else begin
      misaligned <= 1'b0;
      busErr     <= 1'b0;
      case (state)
        IDLE: begin
          if (memWrite || memRead) begin
            isWrite <= memWrite;
            f3Q     <= funct3;
            offQ    <= addr[1:0];
            count   <= '0;
            if (reqMis) begin
              misaligned <= 1'b1;
              state      <= DONE;
            end else begin
              bus.busRead    <= ~memWrite;
              bus.busWrite   <= memWrite;
              bus.busAddr    <= {addr[31:2], 2'b00};
              bus.busSel     <= reqSel;
              bus.busDataOut <= reqData;
              state          <= BUSY;
            end
          end
        end
        BUSY: begin
          if (bus.busAck) begin
            bus.busRead  <= 1'b0;
            bus.busWrite <= 1'b0;
            if (!isWrite)
              loadData <= fmtLoad;
            state <= DONE;
          end else if (count == CW'(TIMEOUT - 1)) begin
            bus.busRead  <= 1'b0;
            bus.busWrite <= 1'b0;
            busErr       <= 1'b1;
            if (!isWrite)
              loadData <= 32'h0;
            state <= DONE;
          end else begin
            count <= count + 1'b1;
          end
        end
        DONE: begin
          count <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_t07_memory_handler.sv
// Directed bench for t07_memory_handler: each task runs one scenario and checks
// strobe counts, lane formatting and pulse widths against hand-computed values.
module tb_t07_memory_handler;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        memRead = 1'b0;
  logic        memWrite = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] storeData = 32'h0;
  logic [31:0] loadData;
  logic        freeze;
  logic        misaligned;
  logic        busErr;

  int vectors = 0;
  int miscompares = 0;

  int          rc, wc, fc, mc, ec;
  logic        finished;
  logic [31:0] ld, seenAddr, seenDout;
  logic [3:0]  seenSel;

  t07_memory_handler_if busIf();

  always #5 clk = ~clk;

  t07_memory_handler #(.TIMEOUT(255)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .funct3     (funct3),
    .addr       (addr),
    .storeData  (storeData),
    .bus        (busIf),
    .loadData   (loadData),
    .freeze     (freeze),
    .misaligned (misaligned),
    .busErr     (busErr)
  );

  // Holds the request through DONE, acks on the ackAt-th BUSY cycle (0 = never),
  // and returns one cycle after DONE with the request dropped.
  task automatic runAccess(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd, input int ackAt);
    int busyCnt = 0;
    rc = 0; wc = 0; fc = 0; mc = 0; ec = 0;
    finished = 1'b0; ld = 32'h0; seenAddr = 32'h0; seenDout = 32'h0; seenSel = 4'b0000;
    memRead = rd; memWrite = wr; funct3 = f3; addr = a; storeData = sd;
    busIf.busAck = 1'b0;
    for (int c = 0; c < 400 && !finished; c++) begin
      if (busIf.busRead || busIf.busWrite) begin
        busyCnt++;
        busIf.busAck = (ackAt != 0) && (busyCnt >= ackAt);
      end else begin
        busIf.busAck = 1'b0;
      end
      @(negedge clk);
      if (freeze) fc++;
      if (busIf.busRead) rc++;
      if (busIf.busWrite) wc++;
      if (misaligned) mc++;
      if (busErr) ec++;
      if (busIf.busRead || busIf.busWrite) begin
        seenSel = busIf.busSel; seenAddr = busIf.busAddr; seenDout = busIf.busDataOut;
      end
      if (!freeze) begin
        finished = 1'b1;
        ld = loadData;
      end
      @(posedge clk); #1;
    end
    memRead = 1'b0; memWrite = 1'b0; busIf.busAck = 1'b0;
    vectors++;
    if (finished !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL access_bound: access did not finish within 400 cycles");
    end
  endtask

  task automatic test_reset();
    busIf.busAck = 1'b0; busIf.busDataIn = 32'h0;
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({busIf.busRead, busIf.busWrite} !== 2'b00) begin
      miscompares++; $display("[TB] FAIL reset_strobes: got %b expected 00", {busIf.busRead, busIf.busWrite});
    end
    vectors++;
    if ({busIf.busSel, busIf.busAddr, busIf.busDataOut} !== 68'h0) begin
      miscompares++; $display("[TB] FAIL reset_bus: sel %b addr %h dout %h expected all 0",
                              busIf.busSel, busIf.busAddr, busIf.busDataOut);
    end
    vectors++;
    if ({loadData, misaligned, busErr, freeze} !== 35'h0) begin
      miscompares++; $display("[TB] FAIL reset_outputs: loadData %h mis %b err %b freeze %b expected 0",
                              loadData, misaligned, busErr, freeze);
    end
    @(posedge clk); #1;
    nrst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_lw();
    busIf.busDataIn = 32'hDEADBEEF;
    runAccess(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 3);
    vectors++;
    if (rc !== 3) begin miscompares++; $display("[TB] FAIL lw_read_cycles: got %0d expected 3", rc); end
    vectors++;
    if (fc !== 4) begin miscompares++; $display("[TB] FAIL lw_freeze_cycles: got %0d expected 4", fc); end
    vectors++;
    if (seenSel !== 4'b1111 || seenAddr !== 32'h100) begin
      miscompares++; $display("[TB] FAIL lw_bus: sel %b addr %h expected 1111 00000100", seenSel, seenAddr);
    end
    vectors++;
    if (ld !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL lw_data: got %h expected deadbeef", ld); end
  endtask

  task automatic test_byte_half_loads();
    busIf.busDataIn = 32'h80000000;
    runAccess(1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 1);
    vectors++;
    if (ld !== 32'hFFFFFF80) begin miscompares++; $display("[TB] FAIL lb_data: got %h expected ffffff80", ld); end
    vectors++;
    if (fc !== 2 || seenSel !== 4'b1000) begin
      miscompares++; $display("[TB] FAIL lb_stall_sel: freeze %0d sel %b expected 2 1000", fc, seenSel);
    end
    runAccess(1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 1);
    vectors++;
    if (ld !== 32'h00000080) begin miscompares++; $display("[TB] FAIL lbu_data: got %h expected 00000080", ld); end
    busIf.busDataIn = 32'h80011234;
    runAccess(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 2);
    vectors++;
    if (ld !== 32'hFFFF8001 || seenSel !== 4'b1100) begin
      miscompares++; $display("[TB] FAIL lh_upper: data %h sel %b expected ffff8001 1100", ld, seenSel);
    end
    runAccess(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 1);
    vectors++;
    if (ld !== 32'h00008001) begin miscompares++; $display("[TB] FAIL lhu_upper: got %h expected 00008001", ld); end
    runAccess(1'b1, 1'b0, 3'b001, 32'h100, 32'h0, 1);
    vectors++;
    if (ld !== 32'h00001234 || seenSel !== 4'b0011) begin
      miscompares++; $display("[TB] FAIL lh_lower: data %h sel %b expected 00001234 0011", ld, seenSel);
    end
    busIf.busDataIn = 32'h89ABCDEF;
    runAccess(1'b1, 1'b0, 3'b011, 32'h104, 32'h0, 1);
    vectors++;
    if (ld !== 32'h89ABCDEF || seenSel !== 4'b1111) begin
      miscompares++; $display("[TB] FAIL undef_funct3: data %h sel %b expected 89abcdef 1111", ld, seenSel);
    end
  endtask

  task automatic test_stores();
    busIf.busDataIn = 32'h55555555;
    runAccess(1'b0, 1'b1, 3'b001, 32'h102, 32'h00001234, 1);
    vectors++;
    if (wc !== 1 || rc !== 0) begin
      miscompares++; $display("[TB] FAIL sh_strobes: write %0d read %0d expected 1 0", wc, rc);
    end
    vectors++;
    if (seenAddr !== 32'h100 || seenSel !== 4'b1100 || seenDout !== 32'h12341234) begin
      miscompares++; $display("[TB] FAIL sh_bus: addr %h sel %b dout %h expected 00000100 1100 12341234",
                              seenAddr, seenSel, seenDout);
    end
    vectors++;
    if (ld !== 32'h89ABCDEF) begin miscompares++; $display("[TB] FAIL store_keeps_load: got %h expected 89abcdef", ld); end
    runAccess(1'b0, 1'b1, 3'b000, 32'h101, 32'h000000AB, 1);
    vectors++;
    if (seenSel !== 4'b0010 || seenDout !== 32'hABABABAB) begin
      miscompares++; $display("[TB] FAIL sb_bus: sel %b dout %h expected 0010 abababab", seenSel, seenDout);
    end
    // both requests high: the store must win
    runAccess(1'b1, 1'b1, 3'b010, 32'h200, 32'hCAFEF00D, 2);
    vectors++;
    if (wc !== 2 || rc !== 0 || seenSel !== 4'b1111 || seenDout !== 32'hCAFEF00D) begin
      miscompares++; $display("[TB] FAIL sw_priority: write %0d read %0d sel %b dout %h expected 2 0 1111 cafef00d",
                              wc, rc, seenSel, seenDout);
    end
  endtask

  task automatic test_misaligned();
    runAccess(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 1);
    vectors++;
    if (rc !== 0 || fc !== 1 || mc !== 1) begin
      miscompares++; $display("[TB] FAIL lw_misaligned: read %0d freeze %0d mis %0d expected 0 1 1", rc, fc, mc);
    end
    @(negedge clk);
    vectors++;
    if (misaligned !== 1'b0 || loadData !== 32'h89ABCDEF) begin
      miscompares++; $display("[TB] FAIL mis_pulse_clear: mis %b loadData %h expected 0 89abcdef", misaligned, loadData);
    end
    @(posedge clk); #1;
    runAccess(1'b0, 1'b1, 3'b001, 32'h103, 32'hFFFF, 1);
    vectors++;
    if (wc !== 0 || mc !== 1) begin
      miscompares++; $display("[TB] FAIL sh_misaligned: write %0d mis %0d expected 0 1", wc, mc);
    end
  endtask

  task automatic test_ack_outside_busy();
    busIf.busAck = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (freeze !== 1'b0 || busIf.busRead !== 1'b0 || loadData !== 32'h89ABCDEF) begin
      miscompares++; $display("[TB] FAIL stray_ack: freeze %b read %b loadData %h expected 0 0 89abcdef",
                              freeze, busIf.busRead, loadData);
    end
    @(posedge clk); #1;
    busIf.busAck = 1'b0;
  endtask

  task automatic test_timeout();
    busIf.busDataIn = 32'h12345678;
    runAccess(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 0);
    vectors++;
    if (rc !== 255 || fc !== 256) begin
      miscompares++; $display("[TB] FAIL timeout_len: read %0d freeze %0d expected 255 256", rc, fc);
    end
    vectors++;
    if (ec !== 1 || ld !== 32'h0) begin
      miscompares++; $display("[TB] FAIL timeout_err: err %0d loadData %h expected 1 00000000", ec, ld);
    end
    @(negedge clk);
    vectors++;
    if (busErr !== 1'b0 || freeze !== 1'b0) begin
      miscompares++; $display("[TB] FAIL timeout_clear: err %b freeze %b expected 0 0", busErr, freeze);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    busIf.busDataIn = 32'h0000007F;
    runAccess(1'b1, 1'b0, 3'b000, 32'h400, 32'h0, 1);
    runAccess(1'b1, 1'b0, 3'b100, 32'h401, 32'h0, 1);
    vectors++;
    if (ld !== 32'h00000000 || fc !== 2) begin
      miscompares++; $display("[TB] FAIL back_to_back: data %h freeze %0d expected 00000000 2", ld, fc);
    end
  endtask

  task automatic test_reset_mid_busy();
    busIf.busDataIn = 32'hAAAAAAAA;
    memRead = 1'b1; funct3 = 3'b010; addr = 32'h500;
    repeat (2) begin @(posedge clk); #1; end
    vectors++;
    if (busIf.busRead !== 1'b1) begin miscompares++; $display("[TB] FAIL pre_reset_busy: read %b expected 1", busIf.busRead); end
    nrst = 1'b0;
    #1;
    vectors++;
    if (busIf.busRead !== 1'b0 || freeze !== 1'b0 || loadData !== 32'h0) begin
      miscompares++; $display("[TB] FAIL async_reset: read %b freeze %b loadData %h expected 0 0 0",
                              busIf.busRead, freeze, loadData);
    end
    memRead = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1;
    @(posedge clk); #1;
    runAccess(1'b0, 1'b1, 3'b010, 32'h40, 32'h11223344, 2);
    vectors++;
    if (wc !== 2 || fc !== 3 || seenDout !== 32'h11223344 || seenAddr !== 32'h40) begin
      miscompares++; $display("[TB] FAIL sw_after_reset: write %0d freeze %0d dout %h addr %h expected 2 3 11223344 00000040",
                              wc, fc, seenDout, seenAddr);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_byte_half_loads();
    test_stores();
    test_misaligned();
    test_ack_outside_busy();
    test_timeout();
    test_back_to_back();
    test_reset_mid_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
